// File: rtl/mux_sel_arbiter_if.sv
// ============================================================================
//  Module      : mux_sel_arbiter_if
//  Description : Request/grant and mux-select bundle between the two
//                requesters, the muxtwo select input and mux_sel_arbiter.
//                Optional switch statistics present when MUXARB_SWCNT_EN
//                is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mux_sel_arbiter_if;
  // Requests from A (mux input a) and B (mux input b)
  logic req_a;
  logic req_b;
  // Arbiter results: mux select, ownership grants, activity flag
  logic sel;
  logic gnt_a;
  logic gnt_b;
  logic busy;
`ifdef MUXARB_SWCNT_EN
  // Handover statistics
  logic [15:0] switch_cnt;
  logic        preempt_seen;
`endif

`ifdef MUXARB_SWCNT_EN
  // Arbiter side
  modport master (
    input  req_a, req_b,
    output sel, gnt_a, gnt_b, busy, switch_cnt, preempt_seen
  );
  // Requester / observer side
  modport slave (
    output req_a, req_b,
    input  sel, gnt_a, gnt_b, busy, switch_cnt, preempt_seen
  );
`else
  // Arbiter side
  modport master (
    input  req_a, req_b,
    output sel, gnt_a, gnt_b, busy
  );
  // Requester / observer side
  modport slave (
    output req_a, req_b,
    input  sel, gnt_a, gnt_b, busy
  );
`endif

endinterface

`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
// ============================================================================
//  Module      : mux_sel_arbiter
//  Description : Two-requester round-robin arbiter owning the select line of
//                a 2:1 datapath mux (muxtwo). Handovers are break-before-make
//                with one dead SWITCH cycle; a holder is preempted after
//                HOLD_MAX consecutive grant cycles when the other side waits.
//                Optional macro MUXARB_SWCNT_EN adds switch_cnt and
//                preempt_seen outputs.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_sel_arbiter #(
  parameter int HOLD_MAX = 8,  // 2 .. 2**CNT_W
  parameter int CNT_W    = 4
) (
  input  logic              clock,
  input  logic              rst_n,
  mux_sel_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_A  = 2'd1,
    ST_GNT_B  = 2'd2,
    ST_SWITCH = 2'd3
  } state_t;

  // Requester identifiers used for pointer/target/select values
  localparam logic c_req_a = 1'b0;
  localparam logic c_req_b = 1'b1;

  // Hold count value at which a waiting requester forces a handover
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(HOLD_MAX - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_tgt;        // requester the SWITCH cycle hands to
  logic             w_tgt_nxt;
  logic             r_last;       // last-granted requester
  logic             w_last_nxt;
  logic [CNT_W-1:0] r_cnt;        // cycles held by current owner, minus one
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sel;
  logic             w_sel_nxt;
  logic             r_gnt_a;
  logic             r_gnt_b;
  logic             r_busy;

  // Owner-relative view of the requests while in a grant state, so both
  // grant states share one set of transition rules.
  logic w_owner;      // 0 = A holds, 1 = B holds (meaningful in GNT_*)
  logic w_req_own;
  logic w_req_oth;
  logic w_cnt_sat;
  logic w_in_gnt;

  assign w_owner   = (r_state == ST_GNT_B);
  assign w_req_own = w_owner ? bus.req_b : bus.req_a;
  assign w_req_oth = w_owner ? bus.req_a : bus.req_b;
  assign w_cnt_sat = (r_cnt == c_cnt_max);
  assign w_in_gnt  = (r_state == ST_GNT_A) || (r_state == ST_GNT_B);

  // State and bookkeeping registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tgt   <= c_req_a;
      r_last  <= c_req_b;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tgt   <= w_tgt_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, round-robin pick, hold counting and select steering
  always_comb begin
    w_state_nxt = r_state;
    w_tgt_nxt   = r_tgt;
    w_last_nxt  = r_last;
    w_cnt_nxt   = '0;
    w_sel_nxt   = r_sel;

    case (r_state)
      ST_IDLE: begin
        // No grant active, so a grant can be issued directly with sel.
        if (bus.req_a && (!bus.req_b || (r_last == c_req_b))) begin
          w_state_nxt = ST_GNT_A;
          w_sel_nxt   = c_req_a;
          w_last_nxt  = c_req_a;
        end else if (bus.req_b) begin
          w_state_nxt = ST_GNT_B;
          w_sel_nxt   = c_req_b;
          w_last_nxt  = c_req_b;
        end
      end

      ST_GNT_A, ST_GNT_B: begin
        if (!w_req_own && w_req_oth) begin
          // Voluntary release with the other side waiting
          w_state_nxt = ST_SWITCH;
          w_tgt_nxt   = ~w_owner;
          w_sel_nxt   = ~w_owner;
        end else if (!w_req_own) begin
          w_state_nxt = ST_IDLE;
        end else if (w_req_oth && w_cnt_sat) begin
          // Owner has had HOLD_MAX cycles; take the mux away
          w_state_nxt = ST_SWITCH;
          w_tgt_nxt   = ~w_owner;
          w_sel_nxt   = ~w_owner;
        end else begin
          // Keep holding; count saturates so a lone owner never wraps
          w_cnt_nxt = w_cnt_sat ? r_cnt : r_cnt + 1'b1;
        end
      end

      ST_SWITCH: begin
        // Dead cycle: only the target may be granted, never the old owner
        if ((r_tgt == c_req_b) ? bus.req_b : bus.req_a) begin
          w_state_nxt = (r_tgt == c_req_b) ? ST_GNT_B : ST_GNT_A;
          w_last_nxt  = r_tgt;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the state being entered
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_sel   <= 1'b0;
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sel   <= w_sel_nxt;
      r_gnt_a <= (w_state_nxt == ST_GNT_A);
      r_gnt_b <= (w_state_nxt == ST_GNT_B);
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign bus.sel   = r_sel;
  assign bus.gnt_a = r_gnt_a;
  assign bus.gnt_b = r_gnt_b;
  assign bus.busy  = r_busy;

`ifdef MUXARB_SWCNT_EN
  logic [15:0] r_switch_cnt;
  logic        r_preempt_seen;
  logic        w_preempt;

  // Forced handover: owner still requesting, other side waiting, count full
  assign w_preempt = w_in_gnt && w_req_own && w_req_oth && w_cnt_sat;

  // SWITCH entry counter (wraps) and sticky preemption flag
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_switch_cnt   <= 16'd0;
      r_preempt_seen <= 1'b0;
    end else begin
      if (w_state_nxt == ST_SWITCH) begin
        r_switch_cnt <= r_switch_cnt + 16'd1;
      end
      if (w_preempt) begin
        r_preempt_seen <= 1'b1;
      end
    end
  end

  assign bus.switch_cnt   = r_switch_cnt;
  assign bus.preempt_seen = r_preempt_seen;
`else
  // Grant-state flag only feeds the statistics logic
  logic w_unused;
  assign w_unused = w_in_gnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
// ============================================================================
//  Module      : tb_mux_sel_arbiter
//  Description : Scoreboard bench for mux_sel_arbiter with a transaction-level
//                ownership model, directed scenarios and random stress. The
//                muxtwo datapath is modelled inline from sel and two random
//                data words. Honours MUXARB_SWCNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mux_sel_arbiter;

  localparam int HOLD_MAX = 8;
  localparam int CNT_W    = 4;
  localparam int NLOG     = 60;

  logic       clock = 1'b0;
  logic       rst_n;
  logic [7:0] dat_a;
  logic [7:0] dat_b;
  logic [7:0] mux_out;

  always #5 clock = ~clock;

  mux_sel_arbiter_if bus ();

  mux_sel_arbiter #(
    .HOLD_MAX (HOLD_MAX),
    .CNT_W    (CNT_W)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // muxtwo behaviour: sl = 0 selects a, 1 selects b
  assign mux_out = bus.sel ? dat_b : dat_a;

  typedef struct packed {
    logic        sel;
    logic        gnt_a;
    logic        gnt_b;
    logic        busy;
    logic [15:0] swc;
    logic        pre;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Ownership model: who holds the mux, for how long, pending handover
  int          m_own;   // -1 none, 0 A, 1 B
  bit          m_gap;   // dead cycle in progress
  int          m_tgt;
  int          m_last;
  int          m_held;  // grant cycles so far for the current owner
  bit          m_sel;
  int unsigned m_swc;
  bit          m_pre;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_gap = 1'b0; m_tgt = 0; m_last = 1; m_held = 0;
    m_sel = 1'b0; m_swc = 0; m_pre = 1'b0;
  endtask

  task automatic handover(input int to);
    m_gap = 1'b1;
    m_tgt = to;
    m_own = -1;
    m_sel = (to == 1);
    m_swc = (m_swc + 1) % 65536;
  endtask

  // Advance the model by one clock given the requests sampled at that edge
  task automatic model_advance(input bit ra, input bit rb);
    bit   r [2];
    int   pick;
    int   oth;
    exp_t e;
    r[0] = ra;
    r[1] = rb;
    if (m_gap) begin
      m_gap = 1'b0;
      if (r[m_tgt]) begin
        m_own = m_tgt; m_held = 1; m_last = m_tgt;
      end
    end else if (m_own < 0) begin
      pick = -1;
      if (r[0] && r[1]) pick = 1 - m_last;
      else if (r[0])    pick = 0;
      else if (r[1])    pick = 1;
      if (pick >= 0) begin
        m_own = pick; m_sel = (pick == 1); m_held = 1; m_last = pick;
      end
    end else begin
      oth = 1 - m_own;
      if (!r[m_own] && r[oth]) handover(oth);
      else if (!r[m_own]) m_own = -1;
      else if (r[oth] && m_held >= HOLD_MAX) begin
        handover(oth);
        m_pre = 1'b1;
      end else m_held++;
    end
    e.sel   = m_sel;
    e.gnt_a = (m_own == 0);
    e.gnt_b = (m_own == 1);
    e.busy  = m_gap || (m_own >= 0);
    e.swc   = m_swc[15:0];
    e.pre   = m_pre;
    exp_q.push_back(e);
  endtask

  // Called at a negedge: drive inputs, predict, advance to the next negedge
  task automatic step(input bit ra, input bit rb);
    bus.req_a = ra;
    bus.req_b = rb;
    dat_a     = 8'($urandom);
    dat_b     = 8'($urandom);
    model_advance(ra, rb);
    @(negedge clock);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    exp_q.delete();
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
  endtask

  // Monitor: compares DUT outputs after every active edge
  initial begin : monitor
    exp_t e;
    logic prev_gnt;
    logic prev_sel;
    prev_gnt = 1'b0;
    prev_sel = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sel_gnta_gntb_busy", {28'd0, bus.sel, bus.gnt_a, bus.gnt_b, bus.busy},
              {28'd0, e.sel, e.gnt_a, e.gnt_b, e.busy});
`ifdef MUXARB_SWCNT_EN
          chk("switch_cnt", {16'd0, bus.switch_cnt}, {16'd0, e.swc});
          chk("preempt_seen", {31'd0, bus.preempt_seen}, {31'd0, e.pre});
`endif
        end
        chk("gnt_exclusive", {31'd0, bus.gnt_a & bus.gnt_b}, 32'd0);
        if (prev_gnt && (bus.gnt_a || bus.gnt_b))
          chk("sel_stable_under_gnt", {31'd0, bus.sel}, {31'd0, prev_sel});
        if (bus.gnt_a) chk("mux_out_a", {24'd0, mux_out}, {24'd0, dat_a});
        if (bus.gnt_b) chk("mux_out_b", {24'd0, mux_out}, {24'd0, dat_b});
        prev_gnt = bus.gnt_a || bus.gnt_b;
        prev_sel = bus.sel;
      end else begin
        prev_gnt = 1'b0;
      end
    end
  end

  // Stimulus
  initial begin : driver
    bit          hist_a [NLOG];
    bit          hist_b [NLOG];
    logic [15:0] hist_sc [NLOG];
    int ib, lb, ia, ia2, la;
    bit ra, rb;

    rst_n     = 1'b0;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    dat_a     = 8'd0;
    dat_b     = 8'd0;
    model_reset();

    // Reset / idle values
    repeat (3) @(negedge clock);
    chk("reset_outputs", {28'd0, bus.sel, bus.gnt_a, bus.gnt_b, bus.busy}, 32'd0);
`ifdef MUXARB_SWCNT_EN
    chk("reset_switch_cnt", {16'd0, bus.switch_cnt}, 32'd0);
`endif
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (3) step(1'b0, 1'b0);

    // Lone requester holds well past HOLD_MAX, then releases
    repeat (50) step(1'b1, 1'b0);
    chk("lone_hold_gnt_a", {31'd0, bus.gnt_a}, 32'd1);
    repeat (2) step(1'b0, 1'b0);

    // Simultaneous start after reset: A first, then handover to B
    do_reset();
    repeat (3) step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0);

    // Preemption cadence with both requesters held
    do_reset();
    repeat (2) step(1'b1, 1'b0);
    for (int i = 0; i < NLOG; i++) begin
      step(1'b1, 1'b1);
      hist_a[i] = bus.gnt_a;
      hist_b[i] = bus.gnt_b;
`ifdef MUXARB_SWCNT_EN
      hist_sc[i] = bus.switch_cnt;
`else
      hist_sc[i] = 16'd0;
`endif
    end
    ib = NLOG; lb = 0; ia = -1; ia2 = -1; la = 0;
    for (int i = 1; i < NLOG; i++)
      if (ib == NLOG && hist_b[i] && !hist_b[i-1]) ib = i;
    while (ib + lb < NLOG && hist_b[ib + lb]) lb++;
    for (int i = ((ib + lb) > 1 ? (ib + lb) : 1); i < NLOG; i++) begin
      if (hist_a[i] && !hist_a[i-1]) begin
        if (ia < 0) ia = i;
        else if (ia2 < 0) ia2 = i;
      end
    end
    if (ia >= 0)
      while (ia + la < NLOG && hist_a[ia + la]) la++;
    chk("preempt_b_run", lb, HOLD_MAX);
    chk("preempt_a_run", la, HOLD_MAX);
    chk("preempt_dead_gap", ia - (ib + lb), 1);
    chk("preempt_period", ia2 - ia, 2 * HOLD_MAX + 2);
`ifdef MUXARB_SWCNT_EN
    if (ia >= 0 && ia2 >= 0)
      chk("swcnt_per_period", {16'd0, 16'(hist_sc[ia2] - hist_sc[ia])}, 32'd2);
    else
      chk("swcnt_period_found", 32'd0, 32'd1);
`endif
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Abandoned handover: B drops during the dead cycle
    do_reset();
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("abandon_sel_b", {29'd0, bus.sel, bus.gnt_a, bus.gnt_b}, 32'h4);

    // Random stress
    ra = 1'b0;
    rb = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) ra = ~ra;
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      step(ra, rb);
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Asynchronous reset while B holds the mux
    do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("pre_async_gnt_b", {31'd0, bus.gnt_b}, 32'd1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_drop", {28'd0, bus.sel, bus.gnt_a, bus.gnt_b, bus.busy}, 32'd0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
